// File: rtl/seq_mini_alu.sv
// Sequential mini ALU: add/sub/shift-add multiply, signed or unsigned, with valid/ready on both sides.
// Optional SEQ_MINI_ALU_BCD_EN adds a double-dabble CONV state and the bcd_out port.
module seq_mini_alu #(
  parameter int unsigned W          = 8,
  parameter int unsigned BCD_DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      op1,
  input  logic [W-1:0]      op2,
  input  logic [1:0]        opcode,
  input  logic              sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    result,
  output logic              neg,
  output logic              err
`ifdef SEQ_MINI_ALU_BCD_EN
  ,
  output logic [4*BCD_DIGITS-1:0] bcd_out
`endif
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned CW = $clog2(RW);

  if (W < 2 || W > 16 || BCD_DIGITS < 1) begin : g_bad_param
    $error("seq_mini_alu: W must be 2..16 and BCD_DIGITS at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
`ifdef SEQ_MINI_ALU_BCD_EN
    CONV = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t state, state_d;

  logic [W-1:0]  a_q, b_q, mb_q, mag_a, mag_b;
  logic [1:0]    opc_q;
  logic          sign_q, mneg_q, a_neg, b_neg, accept;
  logic [RW-1:0] ma_q, acc_q, ea, eb, pp, res_c;
  logic [CW-1:0] cnt_q;
  logic          neg_c, err_c, mul_last, calc_done;

  assign accept = in_valid && in_ready;

  // Magnitudes taken at accept; the signed product is re-negated at the end.
  always_comb begin
    a_neg = sign && op1[W-1];
    b_neg = sign && op2[W-1];
    mag_a = a_neg ? (W'(0) - op1) : op1;
    mag_b = b_neg ? (W'(0) - op2) : op2;
  end

  always_comb begin
    ea        = sign_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    eb        = sign_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
    pp        = acc_q + (mb_q[0] ? ma_q : RW'(0));
    mul_last  = (cnt_q == CW'(W - 1));
    calc_done = (opc_q != 2'b10) || mul_last;
    res_c     = '0;
    neg_c     = 1'b0;
    err_c     = 1'b0;
    case (opc_q)
      2'b00: begin
        res_c = ea + eb;
        neg_c = sign_q && res_c[RW-1];
      end
      2'b01: begin
        res_c = ea - eb;
        neg_c = sign_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
      end
      2'b10: begin
        res_c = mneg_q ? (RW'(0) - pp) : pp;
        neg_c = mneg_q && (pp != RW'(0));
      end
      default: err_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (in_valid) state_d = CALC;
`ifdef SEQ_MINI_ALU_BCD_EN
      CALC: if (calc_done) state_d = CONV;
      CONV: if (cnt_q == CW'(RW - 1)) state_d = DONE;
`else
      CALC: if (calc_done) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

`ifdef SEQ_MINI_ALU_BCD_EN
  localparam int unsigned BW = 4 * BCD_DIGITS;
  logic [RW-1:0] sh_q;
  logic [BW-1:0] bcd_q, adj, bcd_next;

  // Double-dabble step: add 3 to digits >= 5, then shift in the next magnitude bit.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next = BW'({adj, sh_q[RW-1]});
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      opc_q  <= '0;
      sign_q <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
      mneg_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
`ifdef SEQ_MINI_ALU_BCD_EN
      sh_q    <= '0;
      bcd_q   <= '0;
      bcd_out <= '0;
`endif
    end else begin
      if (accept) begin
        a_q    <= op1;
        b_q    <= op2;
        opc_q  <= opcode;
        sign_q <= sign;
        ma_q   <= {{W{1'b0}}, mag_a};
        mb_q   <= mag_b;
        mneg_q <= a_neg ^ b_neg;
        acc_q  <= '0;
        cnt_q  <= '0;
      end
      if (state == CALC) begin
        if (!calc_done) begin
          acc_q <= pp;
          ma_q  <= ma_q << 1;
          mb_q  <= mb_q >> 1;
          cnt_q <= cnt_q + CW'(1);
        end else begin
          result <= res_c;
          neg    <= neg_c;
          err    <= err_c;
`ifdef SEQ_MINI_ALU_BCD_EN
          sh_q  <= neg_c ? (RW'(0) - res_c) : res_c;
          bcd_q <= '0;
          cnt_q <= '0;
`endif
        end
      end
`ifdef SEQ_MINI_ALU_BCD_EN
      if (state == CONV) begin
        bcd_q <= bcd_next;
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(RW - 1)) bcd_out <= bcd_next;
      end
`endif
    end
  end

endmodule
